// File: rtl/screensaver_scene_sequencer.sv
// Per-frame scene controller for the screensaver: bounces the logo, tints on edge hits,
// and fades brightness out and back in around each image change.
module screensaver_scene_sequencer #(
    parameter int H_ACTIVE         = 640,
    parameter int V_ACTIVE         = 480,
    parameter int LOGO_W           = 64,
    parameter int LOGO_H           = 32,
    parameter int NUM_IMAGES       = 3,
    parameter int HOLD_FRAMES      = 600,
    parameter int FADE_STEP_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       auto_en,
    input  logic       pause,
    input  logic [1:0] speed,
    input  logic [1:0] manual_sel,
    input  logic       manual_load,
    output logic [9:0] logo_x,
    output logic [9:0] logo_y,
    output logic [1:0] image_sel,
    output logic [3:0] bright,
    output logic [2:0] tint,
    output logic       bounce_pulse
);

    localparam logic [10:0] X_MAX = 11'(H_ACTIVE - LOGO_W);
    localparam logic [10:0] Y_MAX = 11'(V_ACTIVE - LOGO_H);
    localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam int STEP_W = (FADE_STEP_FRAMES > 1) ? $clog2(FADE_STEP_FRAMES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FADE_STEP_FRAMES - 1);
    localparam logic [1:0] IMG_LAST  = 2'(NUM_IMAGES - 1);
    localparam logic [2:0] IMG_COUNT = 3'(NUM_IMAGES);

    typedef enum logic [1:0] {
        ST_SHOW     = 2'd0,
        ST_FADE_OUT = 2'd1,
        ST_SWITCH   = 2'd2,
        ST_FADE_IN  = 2'd3
    } state_t;

    // One axis step with clamp-and-reverse; result is {hit, neg_dir, pos}.
    function automatic logic [11:0] axis_next(input logic [9:0] pos, input logic neg_dir,
                                              input logic [2:0] step, input logic [10:0] lim);
        logic [10:0] sum_s;
        logic [9:0]  diff_s;
        logic [11:0] res_s;
        sum_s  = {1'b0, pos} + {8'd0, step};
        diff_s = pos - {7'd0, step};
        if (!neg_dir) begin
            if (sum_s > lim) res_s = {1'b1, 1'b1, lim[9:0]};
            else             res_s = {1'b0, 1'b0, sum_s[9:0]};
        end else begin
            if (pos < {7'd0, step}) res_s = {1'b1, 1'b0, 10'd0};
            else                    res_s = {1'b0, 1'b1, diff_s};
        end
        return res_s;
    endfunction

    logic [9:0]        x_r, y_r;
    logic              dx_neg_r, dy_neg_r;
    logic [2:0]        tint_r;
    logic              bounce_r;
    logic [1:0]        image_r, pend_sel_r;
    logic              pend_valid_r;
    logic [3:0]        bright_r;
    logic [HOLD_W-1:0] hold_r;
    logic [STEP_W-1:0] step_r;
    state_t            state_r;

    logic [2:0]  step_s;
    logic [11:0] x_res_s, y_res_s;
    logic        advance_s, hit_s, load_ok_s;

    assign step_s    = {1'b0, speed} + 3'd1;
    assign x_res_s   = axis_next(x_r, dx_neg_r, step_s, X_MAX);
    assign y_res_s   = axis_next(y_r, dy_neg_r, step_s, Y_MAX);
    assign advance_s = frame_tick & ~pause;
    assign hit_s     = x_res_s[11] | y_res_s[11];
    assign load_ok_s = manual_load & ({1'b0, manual_sel} < IMG_COUNT);

    // Logo motion, edge-hit pulse and tint rotation, once per unpaused frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r      <= 10'd0;
            y_r      <= 10'd0;
            dx_neg_r <= 1'b0;
            dy_neg_r <= 1'b0;
            tint_r   <= 3'd0;
            bounce_r <= 1'b0;
        end else if (advance_s) begin
            x_r      <= x_res_s[9:0];
            dx_neg_r <= x_res_s[10];
            y_r      <= y_res_s[9:0];
            dy_neg_r <= y_res_s[10];
            bounce_r <= hit_s;
            if (hit_s) tint_r <= tint_r + 3'd1;
        end else begin
            bounce_r <= 1'b0;
        end
    end

    // Image/fade sequencer plus the pending manual request latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_SHOW;
            image_r      <= 2'd0;
            bright_r     <= 4'd15;
            hold_r       <= '0;
            step_r       <= '0;
            pend_valid_r <= 1'b0;
            pend_sel_r   <= 2'd0;
        end else begin
            if (!pause) begin
                case (state_r)
                    ST_SHOW: begin
                        if (frame_tick) begin
                            if (pend_valid_r || (auto_en && (hold_r == HOLD_LAST))) begin
                                state_r <= ST_FADE_OUT;
                                step_r  <= '0;
                            end else if (hold_r != HOLD_LAST) begin
                                hold_r <= hold_r + HOLD_W'(1);
                            end
                        end
                    end
                    ST_FADE_OUT: begin
                        if (frame_tick) begin
                            if (step_r == STEP_LAST) begin
                                step_r <= '0;
                                if (bright_r <= 4'd1) begin
                                    bright_r <= 4'd0;
                                    state_r  <= ST_SWITCH;
                                end else begin
                                    bright_r <= bright_r - 4'd1;
                                end
                            end else begin
                                step_r <= step_r + STEP_W'(1);
                            end
                        end
                    end
                    ST_SWITCH: begin
                        if (pend_valid_r) begin
                            image_r      <= pend_sel_r;
                            pend_valid_r <= 1'b0;
                        end else if (image_r >= IMG_LAST) begin
                            image_r <= 2'd0;
                        end else begin
                            image_r <= image_r + 2'd1;
                        end
                        step_r  <= '0;
                        state_r <= ST_FADE_IN;
                    end
                    ST_FADE_IN: begin
                        if (frame_tick) begin
                            // A new request reverses the fade from the current level.
                            if (pend_valid_r) begin
                                state_r <= ST_FADE_OUT;
                                step_r  <= '0;
                            end else if (step_r == STEP_LAST) begin
                                step_r <= '0;
                                if (bright_r >= 4'd14) begin
                                    bright_r <= 4'd15;
                                    state_r  <= ST_SHOW;
                                    hold_r   <= '0;
                                end else begin
                                    bright_r <= bright_r + 4'd1;
                                end
                            end else begin
                                step_r <= step_r + STEP_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_r <= ST_SHOW;
                    end
                endcase
            end
            // Placed last so a load in the SWITCH cycle survives the clear.
            if (load_ok_s) begin
                pend_sel_r   <= manual_sel;
                pend_valid_r <= 1'b1;
            end
        end
    end

    assign logo_x       = x_r;
    assign logo_y       = y_r;
    assign image_sel    = image_r;
    assign bright       = bright_r;
    assign tint         = tint_r;
    assign bounce_pulse = bounce_r;

endmodule

// File: tb/tb_screensaver_scene_sequencer.sv
// Self-checking bench: two differently parameterised instances share stimulus and are
// compared against a per-clock behavioural model plus hand-derived constants.
module tb_screensaver_scene_sequencer;

    localparam int XMAX  [2] = '{576, 448};
    localparam int YMAX  [2] = '{448, 448};
    localparam int NIMG  [2] = '{3, 4};
    localparam int HOLD  [2] = '{4, 5};
    localparam int FADE  [2] = '{1, 2};
    localparam int M_SHOW = 0, M_FOUT = 1, M_SW = 2, M_FIN = 3;

    logic       clk, rst_n, frame_tick, auto_en, pause, manual_load;
    logic [1:0] speed, manual_sel;
    logic [9:0] lx [2];
    logic [9:0] ly [2];
    logic [1:0] img [2];
    logic [3:0] br [2];
    logic [2:0] tn [2];
    logic       bp [2];
    logic [29:0] obs [2];
    logic [29:0] reset_word;

    int total, passed;
    int m_x[2], m_y[2], m_dx[2], m_dy[2], m_img[2], m_br[2], m_tint[2];
    int m_mode[2], m_hold[2], m_step[2], m_pv[2], m_ps[2], m_bp[2];

    screensaver_scene_sequencer #(.NUM_IMAGES(3), .HOLD_FRAMES(4), .FADE_STEP_FRAMES(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .auto_en(auto_en), .pause(pause),
        .speed(speed), .manual_sel(manual_sel), .manual_load(manual_load),
        .logo_x(lx[0]), .logo_y(ly[0]), .image_sel(img[0]), .bright(br[0]), .tint(tn[0]),
        .bounce_pulse(bp[0]));

    screensaver_scene_sequencer #(.H_ACTIVE(512), .NUM_IMAGES(4), .HOLD_FRAMES(5),
                                  .FADE_STEP_FRAMES(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .auto_en(auto_en), .pause(pause),
        .speed(speed), .manual_sel(manual_sel), .manual_load(manual_load),
        .logo_x(lx[1]), .logo_y(ly[1]), .image_sel(img[1]), .bright(br[1]), .tint(tn[1]),
        .bounce_pulse(bp[1]));

    assign obs[0] = {lx[0], ly[0], img[0], br[0], tn[0], bp[0]};
    assign obs[1] = {lx[1], ly[1], img[1], br[1], tn[1], bp[1]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [29:0] exp_word(int k);
        return {10'(m_x[k]), 10'(m_y[k]), 2'(m_img[k]), 4'(m_br[k]), 3'(m_tint[k]), 1'(m_bp[k])};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_x[k] = 0; m_y[k] = 0; m_dx[k] = 1; m_dy[k] = 1; m_img[k] = 0; m_br[k] = 15;
            m_tint[k] = 0; m_mode[k] = M_SHOW; m_hold[k] = 0; m_step[k] = 0;
            m_pv[k] = 0; m_ps[k] = 0; m_bp[k] = 0;
        end
    endtask

    // Behaviour of one clock, from the rules: bouncing motion, then the scene sequence.
    task automatic model_clk();
        int s;
        bit hit;
        s = int'(speed) + 1;
        for (int k = 0; k < 2; k++) begin
            m_bp[k] = 0;
            if (frame_tick && !pause) begin
                hit = 0;
                if (m_dx[k] > 0 && m_x[k] + s > XMAX[k])  begin m_x[k] = XMAX[k]; m_dx[k] = -1; hit = 1; end
                else if (m_dx[k] < 0 && m_x[k] < s)      begin m_x[k] = 0; m_dx[k] = 1; hit = 1; end
                else                                     m_x[k] = m_x[k] + m_dx[k] * s;
                if (m_dy[k] > 0 && m_y[k] + s > YMAX[k])  begin m_y[k] = YMAX[k]; m_dy[k] = -1; hit = 1; end
                else if (m_dy[k] < 0 && m_y[k] < s)      begin m_y[k] = 0; m_dy[k] = 1; hit = 1; end
                else                                     m_y[k] = m_y[k] + m_dy[k] * s;
                if (hit) begin m_bp[k] = 1; m_tint[k] = (m_tint[k] + 1) % 8; end
            end
            if (!pause) begin
                if (m_mode[k] == M_SW) begin
                    m_img[k] = m_pv[k] ? m_ps[k] : (m_img[k] + 1) % NIMG[k];
                    m_pv[k] = 0; m_step[k] = 0; m_mode[k] = M_FIN;
                end else if (frame_tick && m_mode[k] == M_SHOW) begin
                    if (m_pv[k] != 0 || (auto_en && m_hold[k] == HOLD[k] - 1)) m_mode[k] = M_FOUT;
                    else if (m_hold[k] < HOLD[k] - 1) m_hold[k]++;
                    m_step[k] = 0;
                end else if (frame_tick && m_mode[k] == M_FOUT) begin
                    m_step[k]++;
                    if (m_step[k] == FADE[k]) begin
                        m_step[k] = 0;
                        m_br[k] = (m_br[k] > 0) ? m_br[k] - 1 : 0;
                        if (m_br[k] == 0) m_mode[k] = M_SW;
                    end
                end else if (frame_tick && m_mode[k] == M_FIN) begin
                    if (m_pv[k] != 0) begin
                        m_mode[k] = M_FOUT; m_step[k] = 0;
                    end else begin
                        m_step[k]++;
                        if (m_step[k] == FADE[k]) begin
                            m_step[k] = 0;
                            m_br[k] = (m_br[k] < 15) ? m_br[k] + 1 : 15;
                            if (m_br[k] == 15) begin m_mode[k] = M_SHOW; m_hold[k] = 0; end
                        end
                    end
                end
            end
            if (manual_load && int'(manual_sel) < NIMG[k]) begin
                m_ps[k] = int'(manual_sel); m_pv[k] = 1;
            end
        end
    endtask

    task automatic cyc(input bit t, input bit ld, input logic [1:0] sel);
        frame_tick = t; manual_load = ld; manual_sel = sel;
        @(posedge clk);
        model_clk();
        @(negedge clk);
        frame_tick = 1'b0; manual_load = 1'b0;
    endtask

    task automatic tick();
        cyc(1'b1, 1'b0, 2'd0);
        cyc(1'b0, 1'b0, 2'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== reset_word) $display("FAIL reset dut%0d: got %h expected %h", k, obs[k], reset_word);
            else passed++;
        end
    endtask

    task automatic test_motion_basic();
        auto_en = 1'b0; pause = 1'b0; speed = 2'd0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 2'd0);
            total++;
            if (bp[0] !== 1'b0) $display("FAIL no_bounce tick%0d: got %b expected 0", i, bp[0]);
            else passed++;
            cyc(1'b0, 1'b0, 2'd0);
        end
        total++;
        if (lx[0] !== 10'd3 || ly[0] !== 10'd3)
            $display("FAIL three_ticks: got x=%0d y=%0d expected x=3 y=3", lx[0], ly[0]);
        else passed++;
    endtask

    task automatic test_corner();
        speed = 2'd3;
        for (int i = 0; i < 111; i++) tick();
        speed = 2'd1;
        cyc(1'b1, 1'b0, 2'd0);
        total++;
        if (lx[1] !== 10'd448 || ly[1] !== 10'd448 || bp[1] !== 1'b1 || tn[1] !== 3'd1)
            $display("FAIL corner: got x=%0d y=%0d pulse=%b tint=%0d expected 448 448 1 1",
                     lx[1], ly[1], bp[1], tn[1]);
        else passed++;
        total++;
        if (obs[0] !== exp_word(0)) $display("FAIL corner_dut0: got %h expected %h", obs[0], exp_word(0));
        else passed++;
        cyc(1'b0, 1'b0, 2'd0);
        total++;
        if (bp[1] !== 1'b0 || tn[1] !== 3'd1)
            $display("FAIL corner_single: got pulse=%b tint=%0d expected 0 1", bp[1], tn[1]);
        else passed++;
        tick();
        total++;
        if (lx[1] !== 10'd446 || ly[1] !== 10'd446)
            $display("FAIL corner_reverse: got x=%0d y=%0d expected 446 446", lx[1], ly[1]);
        else passed++;
    endtask

    task automatic test_right_edge();
        speed = 2'd3;
        for (int i = 0; i < 30; i++) tick();
        speed = 2'd2;
        tick();
        total++;
        if (lx[0] !== 10'd574) $display("FAIL edge_setup: got x=%0d expected 574", lx[0]);
        else passed++;
        speed = 2'd3;
        cyc(1'b1, 1'b0, 2'd0);
        total++;
        if (lx[0] !== 10'd576 || bp[0] !== 1'b1)
            $display("FAIL edge_clamp: got x=%0d pulse=%b expected 576 1", lx[0], bp[0]);
        else passed++;
        cyc(1'b0, 1'b0, 2'd0);
        total++;
        if (bp[0] !== 1'b0) $display("FAIL edge_pulse_width: got %b expected 0", bp[0]);
        else passed++;
        tick();
        total++;
        if (lx[0] !== 10'd572) $display("FAIL edge_reverse: got x=%0d expected 572", lx[0]);
        else passed++;
    endtask

    task automatic test_auto_cycle();
        int tt, exp_b, exp_i;
        do_reset();
        auto_en = 1'b1;
        for (int t = 1; t <= 102; t++) begin
            speed = 2'($urandom_range(0, 3));
            tick();
            tt = (t - 1) % 34 + 1;
            exp_b = (tt <= 4) ? 15 : ((tt <= 19) ? 19 - tt : tt - 19);
            exp_i = ((t - 1) / 34 + ((tt >= 19) ? 1 : 0)) % 3;
            total++;
            if (br[0] !== 4'(exp_b) || img[0] !== 2'(exp_i))
                $display("FAIL auto_cycle t%0d: got bright=%0d image=%0d expected %0d %0d",
                         t, br[0], img[0], exp_b, exp_i);
            else passed++;
            total++;
            if (obs[1] !== exp_word(1)) $display("FAIL auto_dut1 t%0d: got %h expected %h", t, obs[1], exp_word(1));
            else passed++;
        end
    endtask

    task automatic test_manual();
        do_reset();
        auto_en = 1'b0;
        tick(); tick();
        cyc(1'b0, 1'b1, 2'd2);
        for (int t = 0; t < 70; t++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs[k] !== exp_word(k)) $display("FAIL manual dut%0d t%0d: got %h expected %h", k, t, obs[k], exp_word(k));
                else passed++;
            end
        end
        total++;
        if (img[0] !== 2'd2 || img[1] !== 2'd2 || br[0] !== 4'd15 || br[1] !== 4'd15)
            $display("FAIL manual_sel2: got img=%0d,%0d bright=%0d,%0d expected 2,2 15,15", img[0], img[1], br[0], br[1]);
        else passed++;
        cyc(1'b0, 1'b1, 2'd3);
        for (int t = 0; t < 70; t++) tick();
        total++;
        if (img[0] !== 2'd2 || br[0] !== 4'd15 || img[1] !== 2'd3)
            $display("FAIL manual_sel3: got img=%0d bright=%0d img1=%0d expected 2 15 3", img[0], br[0], img[1]);
        else passed++;
        cyc(1'b1, 1'b1, 2'd1);
        cyc(1'b0, 1'b0, 2'd0);
        total++;
        if (br[0] !== 4'd15) $display("FAIL same_tick_load: got bright=%0d expected 15", br[0]);
        else passed++;
        tick();
        total++;
        if (br[0] !== 4'd15) $display("FAIL fade_enter: got bright=%0d expected 15", br[0]);
        else passed++;
        tick();
        total++;
        if (br[0] !== 4'd14) $display("FAIL fade_first_step: got bright=%0d expected 14", br[0]);
        else passed++;
    endtask

    task automatic test_pause_reset();
        pause = 1'b1;
        for (int t = 0; t < 10; t++) begin
            speed = 2'($urandom_range(0, 3));
            tick();
            total++;
            if (br[0] !== 4'd14 || obs[0] !== exp_word(0))
                $display("FAIL pause t%0d: got %h expected %h", t, obs[0], exp_word(0));
            else passed++;
        end
        pause = 1'b0;
        tick();
        total++;
        if (br[0] !== 4'd13) $display("FAIL unpause: got bright=%0d expected 13", br[0]);
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== reset_word) $display("FAIL async_reset dut%0d: got %h expected %h", k, obs[k], reset_word);
            else passed++;
        end
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        bit t, prev_t;
        prev_t = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            t = !prev_t && ($urandom_range(0, 2) == 0);
            prev_t = t;
            pause = ($urandom_range(0, 9) == 0);
            speed = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) auto_en = ~auto_en;
            cyc(t, ($urandom_range(0, 29) == 0), 2'($urandom_range(0, 3)));
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs[k] !== exp_word(k)) $display("FAIL random dut%0d c%0d: got %h expected %h", k, i, obs[k], exp_word(k));
                else passed++;
            end
        end
    endtask

    initial begin
        total = 0; passed = 0;
        reset_word = {10'd0, 10'd0, 2'd0, 4'd15, 3'd0, 1'b0};
        rst_n = 1'b0; frame_tick = 1'b0; auto_en = 1'b0; pause = 1'b0;
        speed = 2'd0; manual_sel = 2'd0; manual_load = 1'b0;
        model_reset();
        test_reset();
        test_motion_basic();
        test_corner();
        test_right_edge();
        test_auto_cycle();
        test_manual();
        test_pause_reset();
        auto_en = 1'b1;
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
